m_decode: RTL and testbench
===========================

Name: m_decode

Overview:
- Message decompress stage for the Kyber-style datapath. It consumes 256 polynomial coefficients, 12 bits each mod Q=3329, one per cycle.
- Each coefficient is compressed to one message bit: bit = round(2*c/Q) mod 2.
- Results are streamed out as a serial bit stream plus packed bytes.
- Sits downstream of the inverse-NTT/subtract stage. Its serial bit output is the same one-bit-per-cycle format that m_encode consumes on m_in.

Parameters:
- N, 256, number of coefficients per message (multiple of 8, power of 2)
- CW, 12, coefficient width in bits
- Q, 3329, modulus
- LO, (Q+3)/4 = 833, lowest coefficient value that decodes to 1
- HI, (3*Q)/4 = 2496, highest coefficient value that decodes to 1

Ports:
- clk      input   1   clock, rising edge
- reset    input   1   asynchronous, active-high reset
- load     input   1   c_in is valid this cycle (accepted only in IDLE)
- start    input   1   begin compute (accepted only in IDLE)
- c_in     input   CW  coefficient input, index order 0..N-1
- compute  output  1   high while in COMPUTE
- valid    output  1   high while m_out carries a message bit
- m_out    output  1   message bit, index order 0..N-1
- byte_valid output 1  one-cycle pulse, m_byte holds 8 packed bits
- m_byte   output  8   packed bits, lowest index at bit 0
- done     output  1   one-cycle pulse after the last bit is output

Behaviour:
- Reset (async, active-high): state=IDLE; all counters 0; coefficient and bit buffers cleared to 0; compute, valid, m_out, byte_valid, m_byte, done all 0. Reset mid-operation aborts and discards all data.
- FSM states: IDLE -> COMPUTE -> OUTPUT -> IDLE.
- IDLE:
  - load=1 writes c_in to coef[load_count], then load_count+1. load_count is log2(N) bits and wraps N-1 -> 0, so a 257th load overwrites index 0.
  - start=1 -> COMPUTE next cycle with compute_count=0 and load_count cleared.
  - load and start in the same cycle: the load is stored first, then the start takes effect.
- COMPUTE (compute=1, N cycles):
  - Each cycle: bits[compute_count] <= (coef[compute_count] >= LO) && (coef[compute_count] <= HI).
  - The compare uses unsigned CW-bit values. Inputs >= Q are not reduced and decode by the same compare (3328 -> 0, 4095 -> 0).
  - compute_count==N-1 -> OUTPUT, valid_count=0.
  - load and start are ignored.
- OUTPUT (N cycles):
  - Cycle k, k=0..N-1: valid=1 and m_out=bits[k]. Both are registered and aligned in the same cycle.
  - When k%8==7: byte_valid=1 and m_byte={bits[k]..bits[k-7]}, with bits[k-7] at bit 0. The same cycle as valid with m_out=bits[k].
  - After k=N-1: valid=0, done=1 for one cycle, state -> IDLE, counters 0.
  - load and start are ignored.
  - m_out and m_byte hold their last values when valid and byte_valid are low.
- Latency: first valid appears N+1 cycles after the start cycle (1 transition cycle + N compute cycles). The total start-to-done latency is 2N+1 cycles.
- The bit buffer is not cleared between messages; each COMPUTE overwrites all N entries.
- The coefficient buffer keeps its values after OUTPUT, so start again without loads re-decodes the same data.

Decomposition:
- Shared package holds the constants Q, N, CW, LO and HI, plus the state enum {IDLE, COMPUTE, OUTPUT}.
- One sub-module is natural: m_compress1, a combinational CW-bit -> 1-bit threshold compare, reused later by ciphertext decompression.

Test Plan:
- Reset, then check outputs: all outputs 0 and state IDLE; assert reset mid-OUTPUT -> valid and done drop immediately, and a fresh load/start then works.
- Boundary values: load 832, 833, 1664, 2496, 2497, 0, 3328, 4095 repeated to 256, then start -> m_out pattern 0,1,1,1,0,0,0,0 per group; every m_byte=0x0E.
- Ramp: coef[i]=i*13 -> m_out[i]=1 exactly for i in 65..192; check byte 8 (i=64..71)=0xFE and byte 24 (i=192..199)=0x01.
- Timing: start one cycle after the 256th load -> compute high 256 cycles; valid high 256 cycles starting N+1 cycles after start; done pulse right after; byte_valid pulses 32 times.
- Protocol: load and start pulses issued during COMPUTE/OUTPUT -> ignored (output unchanged vs reference run); a 257th load overwrites coef[0].
- Back-to-back: a second start with no reload -> identical bit stream. Then load a new 256 values -> only new results appear.

Source files
------------

// File: rtl/m_decode_pkg.sv
// -----------------------------------------------------------------------------
// m_decode_pkg
// Shared constants and state encoding for the message decode (decompress)
// stage and its threshold compare.
//   N   : coefficients per message (multiple of 8, power of 2)
//   CW  : coefficient width in bits
//   Q   : modulus
//   LO  : lowest coefficient value that decodes to 1  ((Q+3)/4)
//   HI  : highest coefficient value that decodes to 1 ((3*Q)/4)
// -----------------------------------------------------------------------------
package m_decode_pkg;

    localparam int N  = 256;
    localparam int CW = 12;
    localparam int Q  = 3329;
    localparam int AW = $clog2(N);

    localparam logic [CW-1:0] LO = CW'((Q + 3) / 4);
    localparam logic [CW-1:0] HI = CW'((3 * Q) / 4);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_OUTPUT  = 2'd2
    } state_t;

endpackage

// File: rtl/m_decode_compress1.sv
// -----------------------------------------------------------------------------
// m_compress1
// Combinational 1-bit compression of one coefficient: round(2*c/Q) mod 2,
// realised as an unsigned window compare LO <= c <= HI. Inputs >= Q are not
// reduced; they fall outside the window and decode to 0.
// Ports:
//   i_coef : CW-bit coefficient
//   o_bit  : decoded message bit
// -----------------------------------------------------------------------------
module m_compress1
    import m_decode_pkg::*;
(
    input  logic [CW-1:0] i_coef,
    output logic          o_bit
);

    assign o_bit = (i_coef >= LO) && (i_coef <= HI);

endmodule

// File: rtl/m_decode.sv
// -----------------------------------------------------------------------------
// m_decode
// Message decompress stage. Collects N coefficients in IDLE, decodes one
// coefficient per cycle in COMPUTE, then streams the N message bits out one
// per cycle in OUTPUT, with a packed byte every 8 bits.
// Ports:
//   i_clk        : clock, rising edge
//   i_reset      : asynchronous active-high reset
//   i_load       : i_c_in valid this cycle (IDLE only)
//   i_start      : begin compute (IDLE only)
//   i_c_in       : coefficient input, index order 0..N-1
//   o_compute    : high while in COMPUTE
//   o_valid      : o_m_out carries a message bit
//   o_m_out      : message bit, index order 0..N-1
//   o_byte_valid : one-cycle pulse, o_m_byte holds 8 packed bits
//   o_m_byte     : packed bits, lowest index at bit 0
//   o_done       : one-cycle pulse after the last bit
// -----------------------------------------------------------------------------
module m_decode
    import m_decode_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_load,
    input  logic          i_start,
    input  logic [CW-1:0] i_c_in,
    output logic          o_compute,
    output logic          o_valid,
    output logic          o_m_out,
    output logic          o_byte_valid,
    output logic [7:0]    o_m_byte,
    output logic          o_done
);

    localparam logic [AW-1:0] CNT_LAST = '1;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_load_cnt;
    logic [AW-1:0] r_cmp_cnt;
    logic [AW-1:0] r_out_cnt;
    logic [CW-1:0] r_coef [N];
    logic [N-1:0]  r_bits;

    logic          w_bit;
    logic          w_last_cmp;
    logic          w_last_out;
    logic          w_emit;
    logic [AW-1:0] w_emit_idx;
    logic          w_emit_byte;

    m_compress1 u_compress1 (
        .i_coef (r_coef[r_cmp_cnt]),
        .o_bit  (w_bit)
    );

    assign w_last_cmp  = (r_cmp_cnt == CNT_LAST);
    assign w_last_out  = (r_out_cnt == CNT_LAST);
    assign w_emit_byte = w_emit && (&w_emit_idx[2:0]);
    assign o_compute   = (r_state == S_COMPUTE);

    // Next state plus a one-cycle lookahead of which bit the output registers
    // must present next cycle, so o_valid/o_m_out line up with OUTPUT cycle k.
    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_emit_idx  = '0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_nxt = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (w_last_cmp) begin
                    w_state_nxt = S_OUTPUT;
                    w_emit      = 1'b1;
                    w_emit_idx  = '0;
                end
            end
            S_OUTPUT: begin
                if (w_last_out) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_emit     = 1'b1;
                    w_emit_idx = r_out_cnt + AW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Counters; all wrap naturally at N since N is a power of 2.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_load_cnt <= '0;
            r_cmp_cnt  <= '0;
            r_out_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_load)  r_load_cnt <= r_load_cnt + AW'(1);
                    // start wins over a same-cycle load for the counter;
                    // the load data itself is still written below
                    if (i_start) begin
                        r_load_cnt <= '0;
                        r_cmp_cnt  <= '0;
                    end
                end
                S_COMPUTE: begin
                    r_cmp_cnt <= r_cmp_cnt + AW'(1);
                    if (w_last_cmp) r_out_cnt <= '0;
                end
                S_OUTPUT: r_out_cnt <= r_out_cnt + AW'(1);
                default: ;
            endcase
        end
    end

    // Coefficient and bit buffers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < N; i++) r_coef[i] <= '0;
            r_bits <= '0;
        end else begin
            if ((r_state == S_IDLE) && i_load) r_coef[r_load_cnt] <= i_c_in;
            if (r_state == S_COMPUTE)          r_bits[r_cmp_cnt]  <= w_bit;
        end
    end

    // Output registers; m_out/m_byte hold between valid cycles
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_valid      <= 1'b0;
            o_m_out      <= 1'b0;
            o_byte_valid <= 1'b0;
            o_m_byte     <= '0;
            o_done       <= 1'b0;
        end else begin
            o_valid      <= w_emit;
            o_byte_valid <= w_emit_byte;
            o_done       <= (r_state == S_OUTPUT) && w_last_out;
            if (w_emit)      o_m_out  <= r_bits[w_emit_idx];
            if (w_emit_byte) o_m_byte <= r_bits[{w_emit_idx[AW-1:3], 3'b000} +: 8];
        end
    end

endmodule

// File: tb/tb_m_decode.sv
module tb_m_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        start;
    logic [11:0] c_in;
    logic        compute;
    logic        valid;
    logic        m_out;
    logic        byte_valid;
    logic [7:0]  m_byte;
    logic        done;

    int checks = 0;
    int errors = 0;

    int         tb_coef [256];
    int         ld_idx;
    logic       q_bits [$];
    logic [7:0] q_bytes [$];
    logic [7:0] rx_bytes [32];
    int         pat [8] = '{832, 833, 1664, 2496, 2497, 0, 3328, 4095};

    m_decode dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_load       (load),
        .i_start      (start),
        .i_c_in       (c_in),
        .o_compute    (compute),
        .o_valid      (valid),
        .o_m_out      (m_out),
        .o_byte_valid (byte_valid),
        .o_m_byte     (m_byte),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic dec(input int c);
        return (c >= 833) && (c <= 2496);
    endfunction

    task automatic chk(input string tag, input int cyc, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic load_val(input int v);
        load = 1'b1;
        c_in = 12'(v);
        @(posedge clk);
        #1;
        load = 1'b0;
        tb_coef[ld_idx] = v;
        ld_idx = (ld_idx + 1) % 256;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ld_idx = 0;
    endtask

    // Push the model's expected stream, start, then compare every cycle from
    // the first COMPUTE cycle (c=1) to one cycle past done (c=514).
    task automatic run_check(input bit inject);
        logic       eb;
        logic [7:0] ebyte;
        logic       last_bit;
        logic [7:0] last_byte;
        bit         exp_comp, exp_val, exp_bv, exp_done;
        int         n_comp, n_val, n_bv;
        q_bits.delete();
        q_bytes.delete();
        for (int i = 0; i < 256; i++) q_bits.push_back(dec(tb_coef[i]));
        for (int b = 0; b < 32; b++) begin
            ebyte = '0;
            for (int j = 0; j < 8; j++) ebyte[j] = dec(tb_coef[8*b + j]);
            q_bytes.push_back(ebyte);
        end
        last_bit = 1'b0;
        last_byte = '0;
        n_comp = 0; n_val = 0; n_bv = 0;
        start_pulse();
        for (int c = 1; c <= 514; c++) begin
            @(negedge clk);
            exp_comp = (c >= 1) && (c <= 256);
            exp_val  = (c >= 257) && (c <= 512);
            exp_bv   = exp_val && (((c - 257) % 8) == 7);
            exp_done = (c == 513);
            n_comp += int'(compute);
            n_val  += int'(valid);
            n_bv   += int'(byte_valid);
            chk("compute", c, 32'(compute), 32'(exp_comp));
            chk("valid", c, 32'(valid), 32'(exp_val));
            chk("byte_valid", c, 32'(byte_valid), 32'(exp_bv));
            chk("done", c, 32'(done), 32'(exp_done));
            if (exp_val) begin
                eb = (q_bits.size() > 0) ? q_bits.pop_front() : 1'bx;
                chk("m_out", c, 32'(m_out), 32'(eb));
                last_bit = eb;
            end
            if (exp_bv) begin
                ebyte = (q_bytes.size() > 0) ? q_bytes.pop_front() : 8'hxx;
                chk("m_byte", c, 32'(m_byte), 32'(ebyte));
                rx_bytes[(c - 257) / 8] = m_byte;
                last_byte = ebyte;
            end
            if (c == 513) begin
                chk("m_out_hold", c, 32'(m_out), 32'(last_bit));
                chk("m_byte_hold", c, 32'(m_byte), 32'(last_byte));
            end
            load  = 1'b0;
            start = 1'b0;
            if (inject && (c == 1 || c == 100 || c == 256 || c == 257 || c == 400 || c == 512)) begin
                load  = 1'b1;
                start = 1'b1;
                c_in  = 12'($urandom_range(0, 4095));
            end
        end
        load  = 1'b0;
        start = 1'b0;
        chk("n_compute", 514, 32'(n_comp), 32'd256);
        chk("n_valid", 514, 32'(n_val), 32'd256);
        chk("n_byte_valid", 514, 32'(n_bv), 32'd32);
        chk("sb_leftover", 514, 32'(q_bits.size() + q_bytes.size()), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        start = 1'b0;
        c_in  = '0;
        ld_idx = 0;
        for (int i = 0; i < 256; i++) tb_coef[i] = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_compute", 0, 32'(compute), 32'd0);
        chk("rst_valid", 0, 32'(valid), 32'd0);
        chk("rst_m_out", 0, 32'(m_out), 32'd0);
        chk("rst_byte_valid", 0, 32'(byte_valid), 32'd0);
        chk("rst_m_byte", 0, 32'(m_byte), 32'd0);
        chk("rst_done", 0, 32'(done), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Boundary values around LO/HI and >= Q
        for (int i = 0; i < 256; i++) load_val(pat[i % 8]);
        run_check(1'b0);
        chk("bnd_byte0", 0, 32'(rx_bytes[0]), 32'h0E);
        chk("bnd_byte31", 0, 32'(rx_bytes[31]), 32'h0E);

        // Ramp i*13
        for (int i = 0; i < 256; i++) load_val(i * 13);
        run_check(1'b0);
        chk("ramp_byte8", 0, 32'(rx_bytes[8]), 32'hFE);
        chk("ramp_byte24", 0, 32'(rx_bytes[24]), 32'h01);

        // Back-to-back without reload, with load/start pulses during the run
        run_check(1'b1);
        run_check(1'b0);
        chk("b2b_byte8", 0, 32'(rx_bytes[8]), 32'hFE);

        // New data, 257 loads: the last overwrites coef[0]
        load_val(0);
        for (int i = 1; i < 256; i++) load_val(int'($urandom_range(0, 4095)));
        load_val(1664);
        run_check(1'b0);
        chk("wrap_bit0", 0, 32'(rx_bytes[0][0]), 32'd1);

        // Reset in the middle of OUTPUT
        for (int i = 0; i < 256; i++) load_val(pat[i % 8]);
        start_pulse();
        repeat (300) @(negedge clk);
        chk("pre_rst_valid", 300, 32'(valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 300, 32'(valid), 32'd0);
        chk("mid_rst_done", 300, 32'(done), 32'd0);
        chk("mid_rst_byte_valid", 300, 32'(byte_valid), 32'd0);
        chk("mid_rst_m_byte", 300, 32'(m_byte), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ld_idx = 0;
        for (int i = 0; i < 256; i++) tb_coef[i] = 0;

        // Cleared buffer decodes to all zeros, then a fresh load works
        run_check(1'b0);
        for (int i = 0; i < 256; i++) load_val(pat[(i + 3) % 8]);
        run_check(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
